// File: rtl/mux_arb.sv
// mux_arb: registered N-to-1 valid/ready channel mux with fixed-priority or
// round-robin arbitration and optional packet locking on i_last.
module mux_arb #(
  parameter int CH_NUM     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 1,
  parameter int LOCK_EN    = 1,
  parameter int SEL_WIDTH  = (CH_NUM > 2) ? $clog2(CH_NUM) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [CH_NUM-1:0]                 i_valid,
  input  logic [CH_NUM-1:0][DATA_WIDTH-1:0] i_data,
  input  logic [CH_NUM-1:0]                 i_last,
  output logic [CH_NUM-1:0]                 o_ready,
  output logic                              o_valid,
  output logic [DATA_WIDTH-1:0]             o_data,
  output logic                              o_last,
  output logic [SEL_WIDTH-1:0]              o_sel,
  input  logic                              i_ready
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam bit RR_MODE   = (ARB_MODE != 0);
  localparam bit LOCK_MODE = (LOCK_EN != 0);
  localparam logic [SEL_WIDTH-1:0] LAST_CH = SEL_WIDTH'(CH_NUM - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_locked;
  logic [SEL_WIDTH-1:0]  r_lock_ch;
  logic [SEL_WIDTH-1:0]  r_ptr;
  logic [SEL_WIDTH-1:0]  w_start;
  logic [SEL_WIDTH-1:0]  w_gnt;
  logic [SEL_WIDTH-1:0]  w_idx;
  logic                  w_found;
  logic                  w_ld;
  logic                  w_xfer;
  logic                  w_last_in;
  logic                  w_close;
  logic [CH_NUM-1:0]     w_ready;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic [SEL_WIDTH-1:0]  r_sel;

  // Grant search: the lock channel wins outright, otherwise scan from the start index.
  always_comb begin
    w_start = RR_MODE ? r_ptr : '0;
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    if (LOCK_MODE && w_locked) begin
      w_found = i_valid[r_lock_ch];
      w_gnt   = r_lock_ch;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        w_idx   = SEL_WIDTH'((int'(w_start) + i) % CH_NUM);
        w_gnt   = (!w_found && i_valid[w_idx]) ? w_idx : w_gnt;
        w_found = w_found | i_valid[w_idx];
      end
    end
  end

  // Handshake decode for the granted channel.
  always_comb begin
    w_ld      = !r_valid || i_ready;
    w_xfer    = w_ld && w_found;
    w_last_in = i_last[w_gnt];
    w_close   = w_xfer && (!LOCK_MODE || w_last_in);
    w_ready   = w_xfer ? ({{(CH_NUM-1){1'b0}}, 1'b1} << w_gnt) : '0;
  end

  // Lock state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock next-state: open on a non-last transfer, close on the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = (LOCK_MODE && w_xfer && !w_last_in) ? ST_LOCKED : ST_IDLE;
      ST_LOCKED: w_state_nxt = (w_xfer && w_last_in) ? ST_IDLE : ST_LOCKED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Lock state decode.
  always_comb begin
    w_locked = (r_state == ST_LOCKED);
  end

  // Lock channel capture on packet start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_ch <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_LOCKED)) begin
      r_lock_ch <= w_gnt;
    end else begin
      r_lock_ch <= r_lock_ch;
    end
  end

  // Round-robin pointer moves past the winner once its arbitration closes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_close) begin
      r_ptr <= (w_gnt == LAST_CH) ? '0 : w_gnt + SEL_WIDTH'(1'b1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Output stage: load on transfer in, drain when consumed with nothing new.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sel   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= i_data[w_gnt];
      r_last  <= w_last_in;
      r_sel   <= w_gnt;
    end else if (w_ld) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_ready = w_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  assign o_sel   = r_sel;

endmodule
